jtag_tap_ctrl: RTL and testbench
================================

// Module: jtag_tap_ctrl
// PURPOSE
//  IEEE 1149.1 TAP controller for the tt_um_jtag top: 16-state TAP FSM, instruction register,
//  BYPASS/IDCODE data registers and TDO mux. Consumes TMS/TDI from the top's dedicated inputs.
//  Drives capture/shift/update strobes and instruction selects to the boundary-scan chain.
//  Reads the chain's serial output back.
// PARAMETERS
//  IR_WIDTH   4             instruction register width, >=2
//  IDCODE     32'h1000_0ACD IDCODE value; bit0 must be 1
// PORTS
//  clk         in  1        TCK; single clock, all state on this clock
//  rst         in  1        asynchronous, active-high reset (acts as TRST)
//  tms         in  1        test mode select, sampled on clk rising edge
//  tdi         in  1        test data in, sampled on clk rising edge
//  tdo         out 1        test data out, updated on clk falling edge
//  tdo_en      out 1        1 while in Shift-IR or Shift-DR (falling-edge registered)
//  bsr_tdo     in  1        serial output of external boundary-scan register
//  capture_dr  out 1        1 in Capture-DR when BSR is selected
//  shift_dr    out 1        1 in Shift-DR when BSR is selected
//  update_dr   out 1        1 in Update-DR when BSR is selected
//  extest      out 1        current instruction is EXTEST
//  sample      out 1        current instruction is SAMPLE/PRELOAD
//  tap_state   out 4        current FSM state encoding (debug)
// BEHAVIOUR
//  - FSM: standard 16 states, transitions on TMS at clk rising edge.
//  - Encodings (shared pkg): TLR=F, RTI=C, SELDR=7, CAPDR=6, SHDR=2, EX1DR=1, PAUSEDR=3,
//    EX2DR=0, UPDDR=5, SELIR=4, CAPIR=E, SHIR=A, EX1IR=9, PAUSEIR=B, EX2IR=8, UPDIR=D.
//  - rst=1: state=TLR; IR=IDCODE opcode; tdo=0; tdo_en=0; all strobes 0; extest=sample=0.
//  - TLR reached by TMS=1 for 5 rising edges from any state; entering TLR loads IDCODE into IR
//    (same as reset).
//  - IR: shift reg loads {..,2'b01} in CAPIR. Shifts LSB-first toward TDO in SHIR (tdi enters
//    MSB). Copied to the active IR on the rising edge leaving UPDIR. Active IR is unchanged
//    while shifting.
//  - Opcodes (IR_WIDTH=4): EXTEST=0000, SAMPLE=0001, IDCODE=0010, BYPASS=1111.
//    Unknown opcodes decode as BYPASS.
//  - BYPASS: 1 bit, captures 0 in CAPDR, shifts tdi in SHDR.
//  - IDCODE: 32-bit, captures IDCODE in CAPDR, shifts LSB-first.
//  - BSR selected by EXTEST/SAMPLE. The strobes are combinational from state & decode;
//    the external chain shifts on the same edge.
//  - TDO mux: SHIR -> IR shift LSB. SHDR -> selected DR LSB (bsr_tdo for BSR).
//    Sampled on falling edge; tdo=0 when tdo_en=0.
//  - Latency: one bit per TCK. A bit shifted in on a rising edge appears on tdo at the falling
//    edge after it reaches the LSB. BYPASS gives exactly one TCK delay tdi->tdo.
//  - Pause/Exit states hold all shift registers; re-entering SHDR resumes without re-capture.
//  - rst asserted mid-shift: immediate TLR; partial IR contents are discarded.
// CONFIGURATION
//  JTAG_USERCODE_EN defined: adds USERCODE opcode 0011 with a 32-bit DR.
//   - Input port usercode[31:0] is captured in CAPDR and shifted like IDCODE.
//  Undefined: no port; opcode 0011 decodes as BYPASS.
// STRUCTURE
//  Package jtag_pkg: tap_state_t enum with the encodings above, opcode localparams,
//  IR_WIDTH default, IDCODE default.
//  One sub-module: jtag_tap_fsm (state register + next-state + state decode).
//  IR, DRs and TDO mux stay in jtag_tap_ctrl.
// TESTING
//  1. rst pulse, then 5x TMS=1 from SHDR -> tap_state=F; IR=0010; tdo_en=0.
//  2. Reset, go to SHDR, shift 32 bits -> tdo yields 0x1000_0ACD LSB-first.
//  3. Load IR=1111 (SHIR captures 01 on tdo first 2 bits), then shift 8'hA5 in SHDR
//     -> tdo = 0 then A5 delayed one clock.
//  4. Load IR=0000 -> extest=1; capture_dr pulses 1 clk in CAPDR.
//     Shift 4 clk -> shift_dr high 4 clk; tdo follows bsr_tdo; update_dr pulses once.
//  5. Shift IDCODE 10 bits, PAUSEDR 3 clk, resume 22 bits -> full IDCODE seen, no re-capture.
//  6. Assert rst during SHIR with partial IR=1111 -> TLR immediately;
//     IR reads IDCODE; sample=extest=0.
//  7. JTAG_USERCODE_EN: IR=0011, usercode=32'hDEAD_BEEF -> shifts out DEADBEEF.
//     Undefined: the same sequence gives 1-clock bypass.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encodings, opcodes, DR selects and default parameters.
package jtag_pkg;

  localparam int unsigned IR_WIDTH_DEFAULT = 4;
  localparam logic [31:0] IDCODE_DEFAULT   = 32'h1000_0ACD;

  localparam int unsigned OPC_EXTEST   = 0;
  localparam int unsigned OPC_SAMPLE   = 1;
  localparam int unsigned OPC_IDCODE   = 2;
  localparam int unsigned OPC_USERCODE = 3;

  typedef enum logic [3:0] {
    TestLogicReset = 4'hF,
    RunTestIdle    = 4'hC,
    SelectDrScan   = 4'h7,
    CaptureDr      = 4'h6,
    ShiftDr        = 4'h2,
    Exit1Dr        = 4'h1,
    PauseDr        = 4'h3,
    Exit2Dr        = 4'h0,
    UpdateDr       = 4'h5,
    SelectIrScan   = 4'h4,
    CaptureIr      = 4'hE,
    ShiftIr        = 4'hA,
    Exit1Ir        = 4'h9,
    PauseIr        = 4'hB,
    Exit2Ir        = 4'h8,
    UpdateIr       = 4'hD
  } tap_state_t;

  typedef enum logic [1:0] {
    DrBypass,
    DrIdcode,
    DrBsr,
    DrUsercode
  } dr_sel_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine with per-state decode strobes.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t state,
  output logic       enter_tlr,
  output logic       capture_dr_st,
  output logic       shift_dr_st,
  output logic       update_dr_st,
  output logic       capture_ir_st,
  output logic       shift_ir_st,
  output logic       update_ir_st
);

  tap_state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TestLogicReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TestLogicReset: state_d = tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  assign state         = state_q;
  // Look-ahead so the IR reload lands on the same edge that enters Test-Logic-Reset.
  assign enter_tlr     = (state_d == TestLogicReset);
  assign capture_dr_st = (state_q == CaptureDr);
  assign shift_dr_st   = (state_q == ShiftDr);
  assign update_dr_st  = (state_q == UpdateDr);
  assign capture_ir_st = (state_q == CaptureIr);
  assign shift_ir_st   = (state_q == ShiftIr);
  assign update_ir_st  = (state_q == UpdateIr);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: IR, BYPASS/IDCODE DRs, BSR strobes and falling-edge TDO.
// Define JTAG_USERCODE_EN to add the USERCODE instruction and its usercode input.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH = IR_WIDTH_DEFAULT,
  parameter logic [31:0] IDCODE   = IDCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tms,
  input  logic        tdi,
  output logic        tdo,
  output logic        tdo_en,
  input  logic        bsr_tdo,
  output logic        capture_dr,
  output logic        shift_dr,
  output logic        update_dr,
  output logic        extest,
  output logic        sample,
  output logic [3:0]  tap_state
`ifdef JTAG_USERCODE_EN
  ,
  input  logic [31:0] usercode
`endif
);

  localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(OPC_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OPC_SAMPLE);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OPC_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef JTAG_USERCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_USERCODE = IR_WIDTH'(OPC_USERCODE);
`endif

  tap_state_t state;
  logic enter_tlr, capture_dr_st, shift_dr_st, update_dr_st;
  logic capture_ir_st, shift_ir_st, update_ir_st;

  jtag_tap_fsm u_fsm (
    .clk           (clk),
    .rst           (rst),
    .tms           (tms),
    .state         (state),
    .enter_tlr     (enter_tlr),
    .capture_dr_st (capture_dr_st),
    .shift_dr_st   (shift_dr_st),
    .update_dr_st  (update_dr_st),
    .capture_ir_st (capture_ir_st),
    .shift_ir_st   (shift_ir_st),
    .update_ir_st  (update_ir_st)
  );

  logic [IR_WIDTH-1:0] ir_q, ir_shift_q;
  logic                bypass_q;
  logic [31:0]         idcode_q;
`ifdef JTAG_USERCODE_EN
  logic [31:0]         usercode_q;
`endif
  dr_sel_t             dr_sel;
  logic                bsr_sel;
  logic                tdo_d;

  // Unknown opcodes fall through to BYPASS.
  always_comb begin
    dr_sel = DrBypass;
    if (ir_q == IR_EXTEST || ir_q == IR_SAMPLE) begin
      dr_sel = DrBsr;
    end else if (ir_q == IR_IDCODE) begin
      dr_sel = DrIdcode;
`ifdef JTAG_USERCODE_EN
    end else if (ir_q == IR_USERCODE) begin
      dr_sel = DrUsercode;
`endif
    end
  end

  // Shift stage and active IR are separate so decode stays stable while shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q       <= IR_IDCODE;
      ir_shift_q <= '0;
    end else begin
      if (capture_ir_st) begin
        ir_shift_q <= IR_CAPTURE;
      end else if (shift_ir_st) begin
        ir_shift_q <= {tdi, ir_shift_q[IR_WIDTH-1:1]};
      end
      if (enter_tlr) begin
        ir_q <= IR_IDCODE;
      end else if (update_ir_st) begin
        ir_q <= ir_shift_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_q   <= 1'b0;
      idcode_q   <= '0;
`ifdef JTAG_USERCODE_EN
      usercode_q <= '0;
`endif
    end else if (capture_dr_st) begin
      bypass_q   <= 1'b0;
      idcode_q   <= IDCODE;
`ifdef JTAG_USERCODE_EN
      usercode_q <= usercode;
`endif
    end else if (shift_dr_st) begin
      if (dr_sel == DrBypass) bypass_q <= tdi;
      if (dr_sel == DrIdcode) idcode_q <= {tdi, idcode_q[31:1]};
`ifdef JTAG_USERCODE_EN
      if (dr_sel == DrUsercode) usercode_q <= {tdi, usercode_q[31:1]};
`endif
    end
  end

  always_comb begin
    tdo_d = 1'b0;
    if (shift_ir_st) begin
      tdo_d = ir_shift_q[0];
    end else if (shift_dr_st) begin
      case (dr_sel)
        DrBsr:      tdo_d = bsr_tdo;
        DrIdcode:   tdo_d = idcode_q[0];
`ifdef JTAG_USERCODE_EN
        DrUsercode: tdo_d = usercode_q[0];
`endif
        default:    tdo_d = bypass_q;
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo    <= tdo_d;
      tdo_en <= shift_ir_st | shift_dr_st;
    end
  end

  assign bsr_sel    = (dr_sel == DrBsr);
  assign capture_dr = capture_dr_st & bsr_sel;
  assign shift_dr   = shift_dr_st & bsr_sel;
  assign update_dr  = update_dr_st & bsr_sel;
  assign extest     = (ir_q == IR_EXTEST);
  assign sample     = (ir_q == IR_SAMPLE);
  assign tap_state  = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: vector table for the FSM walk plus scan sequences.
// Honours JTAG_USERCODE_EN for the USERCODE check.
module tb_jtag_tap_ctrl;

  localparam logic [31:0] IDC = 32'h1000_0ACD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tms = 1'b1;
  logic tdi = 1'b0;
  logic bsr_tdo = 1'b0;
  logic tdo, tdo_en, capture_dr, shift_dr, update_dr, extest, sample;
  logic [3:0] tap_state;
`ifdef JTAG_USERCODE_EN
  logic [31:0] usercode = 32'hDEAD_BEEF;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jtag_tap_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .bsr_tdo    (bsr_tdo),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .extest     (extest),
    .sample     (sample),
    .tap_state  (tap_state)
`ifdef JTAG_USERCODE_EN
    ,
    .usercode   (usercode)
`endif
  );

  typedef struct packed {
    logic       tms;
    logic       tdi;
    logic [3:0] st;
    logic       en;
    logic       tdo;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic t, input logic d, input logic [3:0] s, input logic e,
                     input logic o);
    vec_t v;
    v.tms = t; v.tdi = d; v.st = s; v.en = e; v.tdo = o;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One TCK: inputs set before the rising edge, outputs observed just after the falling edge.
  task automatic tick(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1; tms = 1'b1; tdi = 1'b0; bsr_tdo = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic goto_shdr();
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From TLR or RTI: load an IR value, checking the 01 capture pattern, end in RTI.
  task automatic load_ir(input logic [3:0] val);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("ir_cap_bit0", {31'd0, tdo}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, val[i]);
      if (i == 0) check("ir_cap_bit1", {31'd0, tdo}, 32'd0);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // Shift n bits from Shift-DR, comparing tdo to exp[i] before each shift; exits to Exit1-DR.
  task automatic dr_shift(input string name, input int n, input logic [63:0] din,
                          input logic [63:0] exp);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_bit%0d", name, i), {31'd0, tdo}, {31'd0, exp[i]});
      tick(i == n - 1, din[i]);
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    check("rst_state", {28'd0, tap_state}, 32'hF);
    check("rst_tdo", {31'd0, tdo}, 32'd0);
    check("rst_tdo_en", {31'd0, tdo_en}, 32'd0);
    check("rst_strobes", {29'd0, capture_dr, shift_dr, update_dr}, 32'd0);
    check("rst_ext_smp", {30'd0, extest, sample}, 32'd0);
    rst = 1'b0;

    // FSM walk through all 16 states, ending with 5x TMS=1 from Shift-DR
    add(0, 1, 4'hC, 0, 0); add(1, 1, 4'h7, 0, 0); add(0, 1, 4'h6, 0, 0);
    add(0, 1, 4'h2, 1, 1); add(1, 1, 4'h1, 0, 0); add(0, 1, 4'h3, 0, 0);
    add(1, 1, 4'h0, 0, 0); add(0, 1, 4'h2, 1, 0); add(1, 1, 4'h1, 0, 0);
    add(1, 1, 4'h5, 0, 0); add(1, 1, 4'h7, 0, 0); add(1, 1, 4'h4, 0, 0);
    add(0, 1, 4'hE, 0, 0); add(1, 1, 4'h9, 0, 0); add(0, 1, 4'hB, 0, 0);
    add(1, 1, 4'h8, 0, 0); add(0, 1, 4'hA, 1, 1); add(1, 1, 4'h9, 0, 0);
    add(1, 1, 4'hD, 0, 0); add(0, 1, 4'hC, 0, 0); add(1, 1, 4'h7, 0, 0);
    add(0, 1, 4'h6, 0, 0); add(0, 1, 4'h2, 1, 0); add(1, 1, 4'h1, 0, 0);
    add(1, 1, 4'h5, 0, 0); add(1, 1, 4'h7, 0, 0); add(1, 1, 4'h4, 0, 0);
    add(1, 1, 4'hF, 0, 0); add(1, 1, 4'hF, 0, 0);
    foreach (vq[i]) begin
      tick(vq[i].tms, vq[i].tdi);
      check($sformatf("vec%0d_state", i), {28'd0, tap_state}, {28'd0, vq[i].st});
      check($sformatf("vec%0d_tdo_en", i), {31'd0, tdo_en}, {31'd0, vq[i].en});
      check($sformatf("vec%0d_tdo", i), {31'd0, tdo}, {31'd0, vq[i].tdo});
    end
    check("tlr_ext_smp", {30'd0, extest, sample}, 32'd0);

    // IDCODE after reset
    do_reset();
    goto_shdr();
    dr_shift("idcode", 32, 64'd0, {32'd0, IDC});
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // BYPASS: one-clock delay
    load_ir(4'b1111);
    check("bypass_ext_smp", {30'd0, extest, sample}, 32'd0);
    goto_shdr();
    dr_shift("bypass", 9, {56'd0, 8'hA5}, {55'd0, 8'hA5, 1'b0});
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // EXTEST with BSR strobes
    load_ir(4'b0000);
    check("extest_on", {30'd0, extest, sample}, 32'd2);
    tick(1'b1, 1'b0);
    check("cap_pre", {29'd0, capture_dr, shift_dr, update_dr}, 32'd0);
    tick(1'b0, 1'b0);
    check("cap_pulse", {29'd0, capture_dr, shift_dr, update_dr}, 32'd4);
    bsr_tdo = 1'b1;
    tick(1'b0, 1'b0);
    check("bsr_sh0", {29'd0, capture_dr, shift_dr, update_dr}, 32'd2);
    check("bsr_tdo0", {31'd0, tdo}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      bsr_tdo = (k == 3);
      tick(1'b0, 1'b0);
      check($sformatf("bsr_sh%0d", k), {31'd0, shift_dr}, 32'd1);
      check($sformatf("bsr_tdo%0d", k), {31'd0, tdo}, {31'd0, k == 3});
    end
    bsr_tdo = 1'b0;
    tick(1'b1, 1'b0);
    check("bsr_exit", {29'd0, capture_dr, shift_dr, update_dr}, 32'd0);
    tick(1'b1, 1'b0);
    check("upd_pulse", {29'd0, capture_dr, shift_dr, update_dr}, 32'd1);
    tick(1'b0, 1'b0);
    check("upd_done", {29'd0, capture_dr, shift_dr, update_dr}, 32'd0);

    // SAMPLE decode
    load_ir(4'b0001);
    check("sample_on", {30'd0, extest, sample}, 32'd1);

    // IDCODE with a pause in the middle
    do_reset();
    goto_shdr();
    dr_shift("pause_a", 10, 64'd0, {32'd0, IDC});
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0);
      check($sformatf("pause_st%0d", k), {28'd0, tap_state}, 32'h3);
      check($sformatf("pause_en%0d", k), {31'd0, tdo_en}, 32'd0);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    dr_shift("pause_b", 22, 64'd0, {42'd0, IDC[31:10]});
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // Async reset mid Shift-IR
    load_ir(4'b0001);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("shir_hold_ir", {30'd0, extest, sample}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_state", {28'd0, tap_state}, 32'hF);
    check("arst_ext_smp", {30'd0, extest, sample}, 32'd0);
    check("arst_tdo", {30'd0, tdo, tdo_en}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    goto_shdr();
    dr_shift("arst_idc", 8, 64'd0, {32'd0, IDC});
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // Opcode 0011: USERCODE when enabled, otherwise BYPASS
    load_ir(4'b0011);
    goto_shdr();
`ifdef JTAG_USERCODE_EN
    dr_shift("usercode", 32, 64'd0, {32'd0, 32'hDEAD_BEEF});
`else
    dr_shift("op3_bypass", 9, {56'd0, 8'h3C}, {55'd0, 8'h3C, 1'b0});
`endif
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("final_state", {28'd0, tap_state}, 32'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
